// File: rtl/mod_cnt_ctrl_if.sv
// Handshake/configuration bundle for the programmable modulo-N count sequencer.
// The master drives control and configuration; the slave (the sequencer) drives status.
interface mod_cnt_ctrl_if #(
  parameter int unsigned W = 32'd4
);
  logic         cfg_we;
  logic [W-1:0] cfg_mod;
  logic         cfg_oneshot;
  logic         start;
  logic         stop;
  logic         pause;
  logic         cnt_en;
  logic [W-1:0] cnt;
  logic         tc;
  logic         busy;
  logic         done;
  logic         cfg_err;

  modport master (
    output cfg_we, cfg_mod, cfg_oneshot, start, stop, pause, cnt_en,
    input  cnt, tc, busy, done, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_mod, cfg_oneshot, start, stop, pause, cnt_en,
    output cnt, tc, busy, done, cfg_err
  );
endinterface

// File: rtl/mod_cnt_ctrl.sv
// Programmable modulo-N count sequencer: run-time modulus, start/pause/stop,
// periodic or one-shot operation, one-cycle terminal-count pulse and done flag.
// Every output comes straight from a flop; nothing is combinational from inputs.
module mod_cnt_ctrl #(
  parameter int unsigned W       = 32'd4,
  parameter int unsigned DEF_MOD = 32'd10
) (
  input  logic         clk,
  input  logic         rst,
  mod_cnt_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MOD_RST  = DEF_MOD[W-1:0];

  state_t       state_r, state_nx;
  logic [W-1:0] cnt_r, cnt_nx;
  logic [W-1:0] mod_r, mod_nx;
  logic         oneshot_r, oneshot_nx;
  logic         tc_r, tc_nx;
  logic         busy_r, busy_nx;
  logic         done_r, done_nx;
  logic         cfg_err_r, cfg_err_nx;
  logic         cnt_last;

  // Next-state, next-count and configuration decisions for the coming edge.
  always_comb begin
    state_nx   = state_r;
    cnt_nx     = cnt_r;
    mod_nx     = mod_r;
    oneshot_nx = oneshot_r;
    tc_nx      = 1'b0;
    cfg_err_nx = 1'b0;
    // mod_r is always >= 2, so mod_r-1 never underflows in W bits.
    cnt_last   = (cnt_r == (mod_r - CNT_ONE));

    // Configuration is only accepted while no count is in progress.
    if (bus.cfg_we) begin
      if (((state_r == IDLE) || (state_r == DONE)) && (bus.cfg_mod > CNT_ONE)) begin
        mod_nx     = bus.cfg_mod;
        oneshot_nx = bus.cfg_oneshot;
      end else begin
        cfg_err_nx = 1'b1;
      end
    end else begin
      cfg_err_nx = 1'b0;
    end

    case (state_r)
      IDLE: begin
        cnt_nx = CNT_ZERO;
        if (bus.start) begin
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_nx = IDLE;
          cnt_nx   = CNT_ZERO;
        end else if (bus.start) begin
          state_nx = RUN;
          cnt_nx   = CNT_ZERO;
        end else if (bus.pause) begin
          state_nx = HOLD;
        end else if (bus.cnt_en) begin
          if (cnt_last) begin
            cnt_nx   = CNT_ZERO;
            tc_nx    = 1'b1;
            state_nx = oneshot_r ? DONE : RUN;
          end else begin
            cnt_nx   = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_nx = cnt_r;
        end
      end
      HOLD: begin
        if (bus.stop) begin
          state_nx = IDLE;
          cnt_nx   = CNT_ZERO;
        end else if (bus.start) begin
          state_nx = RUN;
          cnt_nx   = CNT_ZERO;
        end else if (!bus.pause) begin
          state_nx = RUN;
        end else begin
          state_nx = HOLD;
        end
      end
      DONE: begin
        cnt_nx = CNT_ZERO;
        if (bus.stop) begin
          state_nx = IDLE;
        end else if (bus.start) begin
          state_nx = RUN;
        end else begin
          state_nx = DONE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = CNT_ZERO;
      end
    endcase

    busy_nx = (state_nx == RUN) || (state_nx == HOLD);
    done_nx = (state_nx == DONE);
  end

  // State, count, configuration and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      mod_r     <= MOD_RST;
      oneshot_r <= 1'b0;
      tc_r      <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      state_r   <= state_nx;
      cnt_r     <= cnt_nx;
      mod_r     <= mod_nx;
      oneshot_r <= oneshot_nx;
      tc_r      <= tc_nx;
      busy_r    <= busy_nx;
      done_r    <= done_nx;
      cfg_err_r <= cfg_err_nx;
    end
  end

  assign bus.cnt     = cnt_r;
  assign bus.tc      = tc_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.cfg_err = cfg_err_r;

endmodule
